// File: rtl/stream_xbar_rr.sv
// stream_xbar_rr
//   Packet-aware stream crossbar. Each of S_DATA_COUNT input streams carries
//   packets tagged with a destination index. Each of the M_DATA_COUNT outputs
//   has its own round-robin arbiter. The arbiter stays locked to one source
//   from the first beat of a packet through its last beat. Each output drives
//   its sink from a one-entry register slice.
//   Packets whose destination does not exist are discarded (DROP_INVALID=1)
//   or are held off indefinitely (DROP_INVALID=0).
//
// Ports
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   s_data_i      : per-input payload, input i at [i*T_DATA_WIDTH +: T_DATA_WIDTH]
//   s_dest_i      : per-input destination, sampled only on the first beat
//   s_last_i      : per-input end-of-packet flag
//   s_valid_i     : per-input beat valid
//   s_ready_o     : per-input ready (combinational from state and m_ready_i)
//   m_data_o      : per-output payload (registered)
//   m_id_o        : per-output index of the source input (registered)
//   m_last_o      : per-output end-of-packet flag (registered)
//   m_valid_o     : per-output beat valid (registered)
//   m_ready_i     : per-output downstream ready
//   drop_o        : one-cycle pulse after input i finishes a discarded packet
module stream_xbar_rr #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3,
  parameter bit DROP_INVALID = 1'b1,
  localparam int T_ID___WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1,
  localparam int T_DEST_WIDTH = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [S_DATA_COUNT*T_DATA_WIDTH-1:0]   s_data_i,
  input  logic [S_DATA_COUNT*T_DEST_WIDTH-1:0]   s_dest_i,
  input  logic [S_DATA_COUNT-1:0]                s_last_i,
  input  logic [S_DATA_COUNT-1:0]                s_valid_i,
  output logic [S_DATA_COUNT-1:0]                s_ready_o,
  output logic [M_DATA_COUNT*T_DATA_WIDTH-1:0]   m_data_o,
  output logic [M_DATA_COUNT*T_ID___WIDTH-1:0]   m_id_o,
  output logic [M_DATA_COUNT-1:0]                m_last_o,
  output logic [M_DATA_COUNT-1:0]                m_valid_o,
  input  logic [M_DATA_COUNT-1:0]                m_ready_i,
  output logic [S_DATA_COUNT-1:0]                drop_o
);

  localparam int IW = T_ID___WIDTH;
  localparam int DW = T_DEST_WIDTH;
  // Number of outputs at destination width + 1, used to detect invalid dest.
  localparam logic [DW:0] M_LIM = M_DATA_COUNT[DW:0];

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t                                r_state [M_DATA_COUNT];
  logic [IW-1:0]                         r_grant [M_DATA_COUNT];
  logic [IW-1:0]                         r_ptr   [M_DATA_COUNT];
  logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] r_data;
  logic [M_DATA_COUNT-1:0][IW-1:0]       r_id;
  logic [M_DATA_COUNT-1:0]               r_last;
  logic [M_DATA_COUNT-1:0]               r_valid;
  logic [S_DATA_COUNT-1:0]               r_drop;
  logic [S_DATA_COUNT-1:0]               r_drop_pulse;

  logic [DW-1:0]                         w_dest  [S_DATA_COUNT];
  logic [DW-1:0]                         w_owner [S_DATA_COUNT];
  logic [S_DATA_COUNT-1:0]               w_owned;
  logic [S_DATA_COUNT-1:0]               w_free;
  logic [S_DATA_COUNT-1:0]               w_inv;
  logic [M_DATA_COUNT-1:0]               w_found;
  logic [IW-1:0]                         w_sel   [M_DATA_COUNT];
  logic [M_DATA_COUNT-1:0]               w_acc;
  logic [M_DATA_COUNT-1:0]               w_acc_last;

  assign m_data_o  = r_data;
  assign m_id_o    = r_id;
  assign m_last_o  = r_last;
  assign m_valid_o = r_valid;
  assign drop_o    = r_drop_pulse;

  // Input-side status: which output owns each input, and whether it is free.
  always_comb begin
    w_owned = '0;
    for (int i = 0; i < S_DATA_COUNT; i++) begin
      w_dest[i]  = s_dest_i[i*DW +: DW];
      w_owner[i] = '0;
      for (int j = 0; j < M_DATA_COUNT; j++) begin
        logic hit;
        hit        = (r_state[j] == ST_LOCKED) && (r_grant[j] == IW'(i));
        w_owned[i] = w_owned[i] | hit;
        w_owner[i] = hit ? DW'(j) : w_owner[i];
      end
      w_free[i] = ~w_owned[i] & ~r_drop[i];
      // A free, valid input whose destination is not an existing output.
      w_inv[i]  = s_valid_i[i] & w_free[i] & ({1'b0, w_dest[i]} >= M_LIM);
    end
  end

  // Ready: dropping inputs always accept; owned inputs follow their slice.
  always_comb begin
    s_ready_o = '0;
    for (int i = 0; i < S_DATA_COUNT; i++) begin
      logic slot_open;
      slot_open    = ~r_valid[w_owner[i]] | m_ready_i[w_owner[i]];
      s_ready_o[i] = ~rst & (r_drop[i] | (w_owned[i] & slot_open));
    end
  end

  // Round-robin search per output, starting at its pointer.
  always_comb begin
    for (int j = 0; j < M_DATA_COUNT; j++) begin
      w_found[j] = 1'b0;
      w_sel[j]   = '0;
      for (int k = 0; k < S_DATA_COUNT; k++) begin
        logic [IW-1:0] idx;
        logic          req;
        idx        = IW'((int'(r_ptr[j]) + k) % S_DATA_COUNT);
        req        = ~w_found[j] & s_valid_i[idx] & w_free[idx] & (w_dest[idx] == DW'(j));
        w_sel[j]   = req ? idx : w_sel[j];
        w_found[j] = w_found[j] | req;
      end
    end
  end

  // Beat acceptance per output: locked source valid and slice can take it.
  always_comb begin
    for (int j = 0; j < M_DATA_COUNT; j++) begin
      w_acc[j]      = (r_state[j] == ST_LOCKED) & s_valid_i[r_grant[j]] &
                      (~r_valid[j] | m_ready_i[j]);
      w_acc_last[j] = w_acc[j] & s_last_i[r_grant[j]];
    end
  end

  // Per-output arbitration FSM and output register slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < M_DATA_COUNT; j++) begin
        r_state[j] <= ST_IDLE;
        r_grant[j] <= '0;
        r_ptr[j]   <= '0;
      end
      r_data  <= '0;
      r_id    <= '0;
      r_last  <= '0;
      r_valid <= '0;
    end else begin
      for (int j = 0; j < M_DATA_COUNT; j++) begin
        case (r_state[j])
          ST_IDLE: begin
            if (w_found[j]) begin
              r_state[j] <= ST_LOCKED;
              r_grant[j] <= w_sel[j];
            end
          end
          ST_LOCKED: begin
            if (w_acc_last[j]) begin
              r_state[j] <= ST_IDLE;
              // Next search starts just after the source that was served.
              r_ptr[j]   <= (r_grant[j] == IW'(S_DATA_COUNT - 1)) ? '0 : r_grant[j] + 1'b1;
            end
          end
          default: r_state[j] <= ST_IDLE;
        endcase

        if (w_acc[j]) begin
          r_data[j]  <= s_data_i[r_grant[j]*T_DATA_WIDTH +: T_DATA_WIDTH];
          r_last[j]  <= s_last_i[r_grant[j]];
          r_id[j]    <= r_grant[j];
          r_valid[j] <= 1'b1;
        end else if (m_ready_i[j]) begin
          r_valid[j] <= 1'b0;
        end
      end
    end
  end

  // Per-input discard state for packets addressed to a missing output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop       <= '0;
      r_drop_pulse <= '0;
    end else begin
      for (int i = 0; i < S_DATA_COUNT; i++) begin
        if (r_drop[i]) begin
          // Ready is high throughout discard, so valid&last is the final beat.
          r_drop[i]       <= ~(s_valid_i[i] & s_last_i[i]);
          r_drop_pulse[i] <= s_valid_i[i] & s_last_i[i];
        end else begin
          r_drop[i]       <= DROP_INVALID & w_inv[i];
          r_drop_pulse[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_xbar_rr.sv
module tb_stream_xbar_rr;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data_i;
  logic [3:0]  s_dest_i;
  logic [1:0]  s_last_i;
  logic [1:0]  s_valid_i;
  logic [1:0]  s_ready_o;
  logic [23:0] m_data_o;
  logic [2:0]  m_id_o;
  logic [2:0]  m_last_o;
  logic [2:0]  m_valid_o;
  logic [2:0]  m_ready_i;
  logic [1:0]  drop_o;

  // Second instance with stalling behaviour for invalid destinations.
  logic [1:0]  nd_s_ready_o;
  logic [23:0] nd_m_data_o;
  logic [2:0]  nd_m_id_o;
  logic [2:0]  nd_m_last_o;
  logic [2:0]  nd_m_valid_o;
  logic [1:0]  nd_drop_o;

  int n_checks = 0;
  int n_errors = 0;
  int cnt [2];
  int got;
  int phase;
  int pkt;
  int src;
  int bidx;
  logic [1:0] acc;
  logic       stalled;

  always #5 clk = ~clk;

  stream_xbar_rr #(.T_DATA_WIDTH(8), .S_DATA_COUNT(2), .M_DATA_COUNT(3), .DROP_INVALID(1'b1)) dut (
    .clk(clk), .rst(rst),
    .s_data_i(s_data_i), .s_dest_i(s_dest_i), .s_last_i(s_last_i), .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_id_o(m_id_o), .m_last_o(m_last_o), .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i), .drop_o(drop_o)
  );

  stream_xbar_rr #(.T_DATA_WIDTH(8), .S_DATA_COUNT(2), .M_DATA_COUNT(3), .DROP_INVALID(1'b0)) dut_nd (
    .clk(clk), .rst(rst),
    .s_data_i(s_data_i), .s_dest_i(s_dest_i), .s_last_i(s_last_i), .s_valid_i(s_valid_i),
    .s_ready_o(nd_s_ready_o),
    .m_data_o(nd_m_data_o), .m_id_o(nd_m_id_o), .m_last_o(nd_m_last_o), .m_valid_o(nd_m_valid_o),
    .m_ready_i(m_ready_i), .drop_o(nd_drop_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic v, input logic [1:0] d,
                        input logic [7:0] x, input logic l);
    s_valid_i[i]       = v;
    s_dest_i[i*2 +: 2] = d;
    s_data_i[i*8 +: 8] = x;
    s_last_i[i]        = l;
  endtask

  initial begin
    rst       = 1'b1;
    s_data_i  = 16'h0;
    s_dest_i  = 4'h0;
    s_last_i  = 2'b00;
    s_valid_i = 2'b00;
    m_ready_i = 3'b111;
    step();
    step();
    check_val("rst_sready", 32'(s_ready_o), 32'h0);
    check_val("rst_mvalid", 32'(m_valid_o), 32'h0);
    check_val("rst_mdata",  32'(m_data_o),  32'h0);
    check_val("rst_mid",    32'(m_id_o),    32'h0);
    check_val("rst_mlast",  32'(m_last_o),  32'h0);
    check_val("rst_drop",   32'(drop_o),    32'h0);
    rst = 1'b0;
    step();

    // Input 0, 4-beat packet to output 2.
    set_in(0, 1'b1, 2'd2, 8'h10, 1'b0);
    #1;
    check_val("t1_grant_cycle_ready", 32'(s_ready_o), 32'h0);
    step();
    for (int k = 0; k < 4; k++) begin
      set_in(0, 1'b1, 2'd2, 8'(32'h10 + k), (k == 3));
      #1;
      check_val("t1_ready", 32'(s_ready_o), 32'h1);
      step();
      check_val("t1_mvalid", 32'(m_valid_o), 32'h4);
      check_val("t1_data", 32'(m_data_o[16 +: 8]), 32'h10 + 32'(k));
      check_val("t1_id", 32'(m_id_o[2]), 32'h0);
      check_val("t1_last", 32'(m_last_o[2]), (k == 3) ? 32'h1 : 32'h0);
    end
    set_in(0, 1'b0, 2'd0, 8'h00, 1'b0);
    #1;
    check_val("t1_ready_after", 32'(s_ready_o), 32'h0);
    step();
    check_val("t1_drain", 32'(m_valid_o), 32'h0);

    // Both inputs stream 2-beat packets to output 1.
    cnt[0] = 0;
    cnt[1] = 0;
    for (int n = 1; n <= 12; n++) begin
      for (int i = 0; i < 2; i++)
        set_in(i, 1'b1, 2'd1, 8'(32'h40 + 16 * i + cnt[i]), cnt[i][0]);
      #1;
      acc = s_ready_o & s_valid_i;
      step();
      cnt[0] += int'(acc[0]);
      cnt[1] += int'(acc[1]);
      phase = (n - 2) % 3;
      if (n == 1 || phase == 2) begin
        check_val("t2_gap", 32'(m_valid_o[1]), 32'h0);
      end else begin
        pkt  = (n - 2) / 3;
        src  = pkt % 2;
        bidx = (pkt / 2) * 2 + phase;
        check_val("t2_valid", 32'(m_valid_o[1]), 32'h1);
        check_val("t2_id", 32'(m_id_o[1]), 32'(src));
        check_val("t2_data", 32'(m_data_o[8 +: 8]), 32'(32'h40 + 16 * src + bidx));
        check_val("t2_last", 32'(m_last_o[1]), (phase == 1) ? 32'h1 : 32'h0);
      end
    end
    set_in(0, 1'b0, 2'd0, 8'h00, 1'b0);
    set_in(1, 1'b0, 2'd0, 8'h00, 1'b0);
    step();
    step();
    check_val("t2_drain", 32'(m_valid_o), 32'h0);

    // Input 0, 3-beat packet to output 0 with a stalling sink.
    cnt[0]  = 0;
    got     = 0;
    stalled = 1'b0;
    for (int n = 0; n < 18; n++) begin
      if (cnt[0] < 3) set_in(0, 1'b1, 2'd0, 8'(32'h20 + cnt[0]), (cnt[0] == 2));
      else            set_in(0, 1'b0, 2'd0, 8'h00, 1'b0);
      m_ready_i = {2'b11, (n % 3 == 0)};
      #1;
      acc[0] = s_ready_o[0] & s_valid_i[0];
      if (m_valid_o[0] && m_ready_i[0]) begin
        check_val("t3_data", 32'(m_data_o[7:0]), 32'h20 + 32'(got));
        check_val("t3_last", 32'(m_last_o[0]), (got == 2) ? 32'h1 : 32'h0);
        check_val("t3_id", 32'(m_id_o[0]), 32'h0);
        got++;
        stalled = 1'b0;
      end else begin
        stalled = m_valid_o[0];
      end
      step();
      cnt[0] += int'(acc[0]);
      if (stalled) begin
        check_val("t3_hold_valid", 32'(m_valid_o[0]), 32'h1);
        check_val("t3_hold_data", 32'(m_data_o[7:0]), 32'h20 + 32'(got));
      end
    end
    check_val("t3_beats", 32'(got), 32'h3);
    check_val("t3_drain", 32'(m_valid_o), 32'h0);
    m_ready_i = 3'b111;

    // Input 1 changes dest mid-packet; all beats stay on output 0.
    set_in(1, 1'b1, 2'd0, 8'h30, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      set_in(1, 1'b1, (k >= 1) ? 2'd2 : 2'd0, 8'(32'h30 + k), (k == 2));
      #1;
      check_val("t4_ready", 32'(s_ready_o), 32'h2);
      step();
      check_val("t4_mvalid", 32'(m_valid_o), 32'h1);
      check_val("t4_data", 32'(m_data_o[7:0]), 32'h30 + 32'(k));
      check_val("t4_id", 32'(m_id_o[0]), 32'h1);
    end
    set_in(1, 1'b0, 2'd0, 8'h00, 1'b0);
    step();

    // Invalid destination 3: dropped by dut, stalled by dut_nd.
    set_in(0, 1'b1, 2'd3, 8'hAA, 1'b0);
    #1;
    check_val("t5_ready_first", 32'(s_ready_o), 32'h0);
    step();
    check_val("t5_drop_ready", 32'(s_ready_o), 32'h1);
    check_val("t5_nd_stall", 32'(nd_s_ready_o), 32'h0);
    step();
    check_val("t5_no_out", 32'(m_valid_o), 32'h0);
    check_val("t5_no_pulse_yet", 32'(drop_o), 32'h0);
    set_in(0, 1'b1, 2'd3, 8'hAB, 1'b1);
    #1;
    check_val("t5_drop_ready_last", 32'(s_ready_o), 32'h1);
    step();
    check_val("t5_drop_pulse", 32'(drop_o), 32'h1);
    check_val("t5_no_out_last", 32'(m_valid_o), 32'h0);
    check_val("t5_nd_stall_last", 32'(nd_s_ready_o), 32'h0);
    check_val("t5_nd_no_pulse", 32'(nd_drop_o), 32'h0);
    set_in(0, 1'b0, 2'd0, 8'h00, 1'b0);
    step();
    check_val("t5_pulse_clear", 32'(drop_o), 32'h0);

    // Single-beat packet advances output 1 pointer, then reset mid-packet.
    set_in(0, 1'b1, 2'd1, 8'h60, 1'b1);
    step();
    check_val("t6_single_ready", 32'(s_ready_o), 32'h1);
    step();
    check_val("t6_single_valid", 32'(m_valid_o), 32'h2);
    check_val("t6_single_data", 32'(m_data_o[8 +: 8]), 32'h60);
    check_val("t6_single_last", 32'(m_last_o[1]), 32'h1);
    set_in(0, 1'b0, 2'd0, 8'h00, 1'b0);
    set_in(1, 1'b1, 2'd1, 8'h70, 1'b0);
    step();
    step();
    set_in(1, 1'b1, 2'd1, 8'h71, 1'b0);
    step();
    check_val("t6_mid", 32'(m_data_o[8 +: 8]), 32'h71);
    rst = 1'b1;
    set_in(1, 1'b0, 2'd0, 8'h00, 1'b0);
    #1;
    check_val("t6_rst_ready", 32'(s_ready_o), 32'h0);
    step();
    check_val("t6_rst_mvalid", 32'(m_valid_o), 32'h0);
    rst = 1'b0;
    set_in(0, 1'b1, 2'd1, 8'h80, 1'b1);
    set_in(1, 1'b1, 2'd1, 8'h90, 1'b1);
    step();
    check_val("t6_rr_ready", 32'(s_ready_o), 32'h1);
    step();
    check_val("t6_after_rst_id", 32'(m_id_o[1]), 32'h0);
    check_val("t6_after_rst_data", 32'(m_data_o[8 +: 8]), 32'h80);
    set_in(0, 1'b0, 2'd0, 8'h00, 1'b0);
    step();
    step();
    check_val("t6_second_id", 32'(m_id_o[1]), 32'h1);
    check_val("t6_second_data", 32'(m_data_o[8 +: 8]), 32'h90);
    set_in(1, 1'b0, 2'd0, 8'h00, 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_xbar_rr.md
# stream_xbar_rr

Packet-aware stream crossbar: S_DATA_COUNT input streams routed to M_DATA_COUNT output streams by per-packet destination, with one round-robin arbiter per output that locks onto a source for a whole packet (first beat to `last`). Each output has a registered slice, so outputs are glitch-free and timing-isolated from downstream sinks. Packets addressed to a non-existent output are either dropped or stalled, selected by parameter. Sits between stream producers (DMA/parsers) and stream consumers in the datapath.

## Interface
- T_DATA_WIDTH, 8, payload width per beat
- S_DATA_COUNT, 2, number of input streams (>=1)
- M_DATA_COUNT, 3, number of output streams (>=1)
- DROP_INVALID, 1, 1: packets with dest >= M_DATA_COUNT are consumed and discarded; 0: such inputs stall (s_ready_o low)
- T_ID___WIDTH (localparam), max(1, $clog2(S_DATA_COUNT))
- T_DEST_WIDTH (localparam), max(1, $clog2(M_DATA_COUNT))

- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- s_data_i  in  T_DATA_WIDTH x S_DATA_COUNT  input payload
- s_dest_i  in  T_DEST_WIDTH x S_DATA_COUNT  destination output index, sampled on first beat only
- s_last_i  in  S_DATA_COUNT  last beat of packet
- s_valid_i  in  S_DATA_COUNT  input beat valid
- s_ready_o  out  S_DATA_COUNT  input beat accepted when valid&ready
- m_data_o  out  T_DATA_WIDTH x M_DATA_COUNT  output payload (registered)
- m_id_o  out  T_ID___WIDTH x M_DATA_COUNT  index of source input (registered)
- m_last_o  out  M_DATA_COUNT  last beat (registered)
- m_valid_o  out  M_DATA_COUNT  output beat valid (registered)
- m_ready_i  in  M_DATA_COUNT  downstream ready
- drop_o  out  S_DATA_COUNT  one-cycle pulse when input i completes a dropped packet (registered)

## Operation
- Per output j: FSM IDLE/LOCKED, grant register g_j, round-robin pointer p_j (0..S-1).
- IDLE: request set R_j = {i : s_valid_i[i], s_dest_i[i]==j, input i not owned}. If R_j non-empty, grant first i in R_j searching p_j, p_j+1, … mod S; next cycle LOCKED with g_j=i, input i owned. No beat transfers in the grant cycle.
- An input is owned by at most one output; since dest is single-valued, two outputs never grant the same input in one cycle.
- LOCKED: s_ready_o[g_j] = !m_valid_o[j] | m_ready_i[j]. Accepted beat loads slice: m_data_o/m_last_o from input, m_id_o=g_j, m_valid_o=1. s_dest_i ignored while locked (mid-packet dest change has no effect).
- Slice with no accept and m_ready_i[j]=1 clears m_valid_o[j]; with m_ready_i[j]=0 holds all m_* stable.
- Accepted beat with s_last_i=1: next cycle IDLE, p_j=(g_j+1) mod S, input released.
- Invalid dest (s_dest_i[i] >= M_DATA_COUNT) on an un-owned valid input: DROP_INVALID=1 → input enters DROP state next cycle; s_ready_o[i]=1 in DROP; beats discarded; on accepted last beat drop_o[i]=1 next cycle, input returns free. DROP_INVALID=0 → s_ready_o[i]=0 indefinitely.
- Single-beat packet (last on first beat) is legal: one grant cycle, one transfer cycle.
- Inputs not owned and not dropping: s_ready_o=0.

## Timing
- Reset (rst=1 at edge): all FSMs IDLE, p_j=0, no ownership, m_valid_o=0, m_data_o=0, m_id_o=0, m_last_o=0, drop_o=0; s_ready_o=0 combinationally while rst high. Reset mid-packet aborts it; no further beats of that packet appear.
- Latency: input valid with dest j at cycle 0 (output IDLE) → s_ready_o at cycle 1 → m_valid_o at cycle 2.
- Throughput: 1 beat/cycle per output while locked and m_ready_i=1; one idle cycle between packets on the same output (re-arbitration).
- Different outputs operate fully in parallel; S simultaneous packets to S distinct outputs all flow at full rate.
- s_ready_o is combinational from m_ready_i and state; m_* and drop_o are registered only.
- Inputs must hold data/dest/last stable while valid&!ready (standard stream rule).

## Test plan
- S=2,M=3: input 0 sends 4-beat packet (0x10..0x13) dest 2 → m_valid_o[2] from cycle 2, data 0x10..0x13, m_id_o=0, m_last_o on 0x13, 1 beat/cycle.
- Both inputs request output 1 continuously, 2-beat packets → grants alternate 0,1,0,1; no interleaving of beats within a packet; one gap cycle between packets.
- Output 0 with m_ready_i toggling 1,0,0,1,… on 3-beat packet → m_data_o held stable while stalled, no beat lost or duplicated, order preserved.
- Input 1 changes s_dest_i from 0 to 2 on beat 2 of a 3-beat packet → all 3 beats on output 0.
- DROP_INVALID=1, dest=3 (M=3), 2-beat packet → both beats accepted, nothing on any m_valid_o, drop_o[i] one-cycle pulse; DROP_INVALID=0 → s_ready_o stays 0.
- Assert rst mid-packet → next cycle all m_valid_o=0, s_ready_o=0; following packet routed normally with p_j=0.
